// File: rtl/udp_payload_tx_if.sv
// Payload RAM read port and outgoing byte stream of udp_payload_tx.
interface udp_payload_tx_if;
  logic [9:0]  rd_addr;
  logic [31:0] rd_data;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;

  modport master (
    output rd_addr,
    input  rd_data,
    output out_data,
    output out_valid,
    input  out_ready,
    output out_last
  );

  modport slave (
    input  rd_addr,
    output rd_data,
    input  out_data,
    input  out_valid,
    output out_ready,
    input  out_last
  );
endinterface

// File: rtl/udp_payload_tx.sv
// Streams a payload frame from a 32-bit synchronous-read RAM as bytes, LSB first.
// Define UDP_PAYLOAD_TX_STRIP_FCS_EN to drop the trailing FCS word at last_addr.
module udp_payload_tx #(
  parameter logic [9:0] START_ADDR = 10'd0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_read,
  input  logic [9:0]       last_addr,
  output logic             busy,
  output logic             done,
  output logic [12:0]      byte_cnt,
  udp_payload_tx_if.master bus
);

  typedef enum logic [2:0] {IDLE, ADDR, WAIT, SEND, DONE} state_t;

  state_t      state;
  state_t      next_state;
  logic [9:0]  end_addr;
  logic [9:0]  final_addr;
  logic [31:0] word;
  logic [1:0]  byte_idx;
  logic [1:0]  next_idx;
  logic        empty;
  logic        final_word;
  logic        accept;

  // A frame is empty when the borrow of (last - start [- 1]) is set.
`ifdef UDP_PAYLOAD_TX_STRIP_FCS_EN
  assign empty      = (({1'b0, last_addr} - {1'b0, START_ADDR} - 11'd1) >> 10) != 11'd0;
  assign final_addr = end_addr - 10'd1;
`else
  assign empty      = (({1'b0, last_addr} - {1'b0, START_ADDR}) >> 10) != 11'd0;
  assign final_addr = end_addr;
`endif

  assign final_word = (bus.rd_addr == final_addr);
  assign accept     = bus.out_valid && bus.out_ready;
  assign next_idx   = byte_idx + 2'd1;
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start_read) begin
          next_state = empty ? DONE : ADDR;
        end
      end
      ADDR:    next_state = WAIT;
      WAIT:    next_state = SEND;
      SEND: begin
        if (accept && (byte_idx == 2'd3)) begin
          next_state = final_word ? DONE : ADDR;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The first SEND cycle only loads byte 0, so out_valid trails the word capture by one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      end_addr      <= '0;
      word          <= '0;
      byte_idx      <= '0;
      byte_cnt      <= '0;
      bus.rd_addr   <= START_ADDR;
      bus.out_data  <= '0;
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_read) begin
            end_addr    <= last_addr;
            bus.rd_addr <= START_ADDR;
            byte_cnt    <= '0;
          end
        end
        WAIT: begin
          word     <= bus.rd_data;
          byte_idx <= 2'd0;
        end
        SEND: begin
          if (!bus.out_valid) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= word[7:0];
            bus.out_last  <= 1'b0;
          end else if (bus.out_ready) begin
            byte_cnt <= byte_cnt + 13'd1;
            if (byte_idx == 2'd3) begin
              bus.out_valid <= 1'b0;
              bus.out_last  <= 1'b0;
              if (!final_word) begin
                bus.rd_addr <= bus.rd_addr + 10'd1;
              end
            end else begin
              byte_idx     <= next_idx;
              bus.out_data <= word[{next_idx, 3'b000} +: 8];
              bus.out_last <= final_word && (next_idx == 2'd3);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_udp_payload_tx.sv
// Randomized self-checking bench for udp_payload_tx against a byte-list frame model.
module tb_udp_payload_tx;
  logic        clk        = 1'b0;
  logic        rst        = 1'b1;
  logic        start_read = 1'b0;
  logic [9:0]  last_addr  = '0;
  logic        busy;
  logic        done;
  logic [12:0] byte_cnt;

  udp_payload_tx_if bus ();

  udp_payload_tx dut (
    .clk        (clk),
    .rst        (rst),
    .start_read (start_read),
    .last_addr  (last_addr),
    .busy       (busy),
    .done       (done),
    .byte_cnt   (byte_cnt),
    .bus        (bus)
  );

  int          errors     = 0;
  int          checks     = 0;
  int          cyc        = 0;
  int          ready_mode = 0;
  bit          phase      = 1'b0;
  logic [31:0] ram [0:1023];

  logic [7:0]  got_data [$];
  bit          got_last [$];
  int          rise_q   [$];
  int          fall_q   [$];
  int          stall_viol = 0;
  int          done_cnt   = 0;
  bit          prev_valid = 1'b0;
  bit          stalled    = 1'b0;
  logic [7:0]  held_data  = '0;
  logic        held_last  = 1'b0;

  logic [7:0]  exp_data [$];
  int          f_data_base, f_rise_base, f_fall_base, f_done_base, f_stall_base, f_start;
  bit          f_timeout;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) bus.rd_data <= ram[bus.rd_addr];

  initial begin
    forever begin
      @(posedge clk);
      #1;
      phase = ~phase;
      case (ready_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = phase;
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Observe the stream between edges: bytes that will transfer, burst edges, stall stability.
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    if (bus.out_valid === 1'b1) begin
      if (!prev_valid) rise_q.push_back(cyc);
      if (stalled && (bus.out_data !== held_data || bus.out_last !== held_last))
        stall_viol <= stall_viol + 1;
      if (bus.out_ready === 1'b1) begin
        got_data.push_back(bus.out_data);
        got_last.push_back(bus.out_last);
        stalled <= 1'b0;
      end else begin
        stalled   <= 1'b1;
        held_data <= bus.out_data;
        held_last <= bus.out_last;
      end
    end else begin
      if (prev_valid) fall_q.push_back(cyc);
      stalled <= 1'b0;
    end
    prev_valid <= (bus.out_valid === 1'b1);
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int eff_last(input logic [9:0] la);
`ifdef UDP_PAYLOAD_TX_STRIP_FCS_EN
    return int'(la) - 1;
`else
    return int'(la);
`endif
  endfunction

  // Reference: every emitted word contributes its four bytes, least significant first.
  task automatic build_expected(input logic [9:0] la);
    logic [31:0] w;
    exp_data.delete();
    for (int a = 0; a <= eff_last(la); a++) begin
      w = ram[a];
      for (int b = 0; b < 4; b++) exp_data.push_back(w[8*b +: 8]);
    end
  endtask

  task automatic drive_frame(input logic [9:0] la, input int mode, input int budget,
                             input int pulse_at, input bit pulse_on_done);
    ready_mode   = mode;
    f_data_base  = got_data.size();
    f_rise_base  = rise_q.size();
    f_fall_base  = fall_q.size();
    f_done_base  = done_cnt;
    f_stall_base = stall_viol;
    @(posedge clk);
    #1;
    start_read = 1'b1;
    last_addr  = la;
    f_start    = cyc + 1;
    @(posedge clk);
    #1;
    start_read = 1'b0;
    last_addr  = 10'($urandom);
    f_timeout  = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      start_read = (i == pulse_at);
      if (i == pulse_at) last_addr = 10'd5;
      if (done === 1'b1) begin
        f_timeout = 1'b0;
        break;
      end
    end
    if (pulse_on_done && !f_timeout) begin
      start_read = 1'b1;
      last_addr  = 10'd0;
      @(negedge clk);
      start_read = 1'b0;
    end
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got=%0b exp=0", bus.out_valid); end
    checks++; if (bus.out_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_out_data got=%0h exp=0", bus.out_data); end
    checks++; if (bus.out_last !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_last got=%0b exp=0", bus.out_last); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got=%0b exp=0", done); end
    checks++; if (byte_cnt !== 13'd0) begin errors++; $display("[TB] FAIL reset_byte_cnt got=%0d exp=0", byte_cnt); end
    checks++; if (bus.rd_addr !== 10'd0) begin errors++; $display("[TB] FAIL reset_rd_addr got=%0d exp=0", bus.rd_addr); end
    @(posedge clk);
    #2 rst = 1'b1;
  endtask

  task automatic test_ready_patterns();
    for (int f = 0; f < 6; f++) begin
      logic [9:0] la;
      int mode, n, bad, words, nr, gap_bad;
      if (f < 2) begin
        ram[0] = 32'h44332211;
        ram[1] = 32'h88776655;
        ram[2] = 32'hCCBBAA99;
        la     = 10'd2;
        mode   = f;
      end else begin
        for (int a = 0; a < 16; a++) ram[a] = $urandom;
        la   = 10'($urandom_range(0, 12));
        mode = (f < 4) ? 2 : f - 4;
      end
      build_expected(la);
      drive_frame(la, mode, 3000, -1, 1'b0);
      checks++; if (f_timeout) begin errors++; $display("[TB] FAIL frame%0d_done_wait got=timeout exp=done", f); end
      n = got_data.size() - f_data_base;
      checks++; if (n != exp_data.size()) begin errors++; $display("[TB] FAIL frame%0d_byte_count got=%0d exp=%0d", f, n, exp_data.size()); end
      bad = 0;
      for (int i = 0; i < n && i < exp_data.size(); i++)
        if (got_data[f_data_base+i] !== exp_data[i] || got_last[f_data_base+i] != (i == exp_data.size() - 1)) bad++;
      if (exp_data.size() > 0) begin
        checks++; if (bad != 0) begin errors++; $display("[TB] FAIL frame%0d_byte_seq got=%0d wrong bytes exp=0", f, bad); end
      end
      checks++; if (byte_cnt !== 13'(exp_data.size())) begin errors++; $display("[TB] FAIL frame%0d_byte_cnt got=%0d exp=%0d", f, byte_cnt, exp_data.size()); end
      checks++; if (done_cnt - f_done_base != 1) begin errors++; $display("[TB] FAIL frame%0d_done_pulses got=%0d exp=1", f, done_cnt - f_done_base); end
      words = exp_data.size() / 4;
      nr    = rise_q.size() - f_rise_base;
      checks++; if (nr != words) begin errors++; $display("[TB] FAIL frame%0d_valid_bursts got=%0d exp=%0d", f, nr, words); end
      if (words > 0 && nr > 0) begin
        checks++; if (rise_q[f_rise_base] - f_start != 3) begin errors++; $display("[TB] FAIL frame%0d_first_valid_latency got=%0d exp=3", f, rise_q[f_rise_base] - f_start); end
      end
      if (words > 1) begin
        gap_bad = 0;
        for (int w = 1; w < words && w < nr && (w - 1) < (fall_q.size() - f_fall_base); w++)
          if (rise_q[f_rise_base+w] - fall_q[f_fall_base+w-1] != 3) gap_bad++;
        checks++; if (gap_bad != 0) begin errors++; $display("[TB] FAIL frame%0d_word_gap got=%0d bad gaps exp=0", f, gap_bad); end
      end
      checks++; if (stall_viol - f_stall_base != 0) begin errors++; $display("[TB] FAIL frame%0d_stall_stable got=%0d changes exp=0", f, stall_viol - f_stall_base); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL frame%0d_busy_after got=%0b exp=0", f, busy); end
    end
  endtask

  task automatic test_single_word();
    int n;
    ram[0] = $urandom;
    build_expected(10'd0);
    drive_frame(10'd0, 0, 200, -1, 1'b0);
    checks++; if (f_timeout) begin errors++; $display("[TB] FAIL single_done_wait got=timeout exp=done"); end
    n = got_data.size() - f_data_base;
    checks++; if (n != exp_data.size()) begin errors++; $display("[TB] FAIL single_byte_count got=%0d exp=%0d", n, exp_data.size()); end
    if (exp_data.size() == 4 && n == 4) begin
      checks++; if (got_data[f_data_base+3] !== exp_data[3] || got_last[f_data_base+3] != 1'b1 || got_last[f_data_base] != 1'b0) begin
        errors++; $display("[TB] FAIL single_last_byte got=%0h/%0b exp=%0h/1", got_data[f_data_base+3], got_last[f_data_base+3], exp_data[3]);
      end
    end
    checks++; if (byte_cnt !== 13'(exp_data.size())) begin errors++; $display("[TB] FAIL single_byte_cnt got=%0d exp=%0d", byte_cnt, exp_data.size()); end
    checks++; if (done_cnt - f_done_base != 1) begin errors++; $display("[TB] FAIL single_done_pulses got=%0d exp=1", done_cnt - f_done_base); end
  endtask

  task automatic test_restart_ignored();
    int n, bad;
    for (int a = 0; a < 8; a++) ram[a] = $urandom;
    build_expected(10'd2);
    drive_frame(10'd2, 0, 300, 4, 1'b1);
    checks++; if (f_timeout) begin errors++; $display("[TB] FAIL restart_done_wait got=timeout exp=done"); end
    n = got_data.size() - f_data_base;
    checks++; if (n != exp_data.size()) begin errors++; $display("[TB] FAIL restart_byte_count got=%0d exp=%0d", n, exp_data.size()); end
    bad = 0;
    for (int i = 0; i < n && i < exp_data.size(); i++)
      if (got_data[f_data_base+i] !== exp_data[i] || got_last[f_data_base+i] != (i == exp_data.size() - 1)) bad++;
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL restart_byte_seq got=%0d wrong bytes exp=0", bad); end
    checks++; if (byte_cnt !== 13'(exp_data.size())) begin errors++; $display("[TB] FAIL restart_byte_cnt got=%0d exp=%0d", byte_cnt, exp_data.size()); end
    checks++; if (done_cnt - f_done_base != 1) begin errors++; $display("[TB] FAIL restart_done_pulses got=%0d exp=1", done_cnt - f_done_base); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL restart_in_done_ignored got busy=%0b exp=0", busy); end
  endtask

  task automatic test_reset_mid_frame();
    int  base, dbase, n, bad;
    bit  hit;
    for (int a = 0; a < 8; a++) ram[a] = $urandom;
    ready_mode = 0;
    base  = got_data.size();
    dbase = done_cnt;
    @(posedge clk);
    #1;
    start_read = 1'b1;
    last_addr  = 10'd3;
    @(posedge clk);
    #1;
    start_read = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (got_data.size() - base >= 7 && bus.out_valid === 1'b1) begin
        hit = 1'b1;
        break;
      end
    end
    checks++; if (!hit) begin errors++; $display("[TB] FAIL midrst_reach_byte got=timeout exp=word1_byte2"); end
    checks++; if (byte_cnt !== 13'd6) begin errors++; $display("[TB] FAIL midrst_cnt_before got=%0d exp=6", byte_cnt); end
    rst = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_valid_async got=%0b exp=0", bus.out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy got=%0b exp=0", busy); end
    checks++; if (byte_cnt !== 13'd0) begin errors++; $display("[TB] FAIL midrst_byte_cnt got=%0d exp=0", byte_cnt); end
    checks++; if (bus.rd_addr !== 10'd0) begin errors++; $display("[TB] FAIL midrst_rd_addr got=%0d exp=0", bus.rd_addr); end
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    checks++; if (done_cnt != dbase) begin errors++; $display("[TB] FAIL midrst_no_done got=%0d exp=0", done_cnt - dbase); end
    ram[0] = $urandom;
    build_expected(10'd0);
    drive_frame(10'd0, 0, 200, -1, 1'b0);
    n = got_data.size() - f_data_base;
    checks++; if (n != exp_data.size()) begin errors++; $display("[TB] FAIL midrst_next_count got=%0d exp=%0d", n, exp_data.size()); end
    bad = 0;
    for (int i = 0; i < n && i < exp_data.size(); i++)
      if (got_data[f_data_base+i] !== exp_data[i] || got_last[f_data_base+i] != (i == exp_data.size() - 1)) bad++;
    if (exp_data.size() > 0) begin
      checks++; if (bad != 0) begin errors++; $display("[TB] FAIL midrst_next_seq got=%0d wrong bytes exp=0", bad); end
    end
    checks++; if (byte_cnt !== 13'(exp_data.size())) begin errors++; $display("[TB] FAIL midrst_next_byte_cnt got=%0d exp=%0d", byte_cnt, exp_data.size()); end
    checks++; if (done_cnt - f_done_base != 1) begin errors++; $display("[TB] FAIL midrst_next_done got=%0d exp=1", done_cnt - f_done_base); end
  endtask

  task automatic test_max_frame();
    int n, bad;
    for (int a = 0; a < 1024; a++) ram[a] = $urandom;
    build_expected(10'd1023);
    drive_frame(10'd1023, 0, 10000, -1, 1'b0);
    checks++; if (f_timeout) begin errors++; $display("[TB] FAIL max_done_wait got=timeout exp=done"); end
    n = got_data.size() - f_data_base;
    checks++; if (n != exp_data.size()) begin errors++; $display("[TB] FAIL max_byte_count got=%0d exp=%0d", n, exp_data.size()); end
    bad = 0;
    for (int i = 0; i < n && i < exp_data.size(); i++)
      if (got_data[f_data_base+i] !== exp_data[i] || got_last[f_data_base+i] != (i == exp_data.size() - 1)) bad++;
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL max_byte_seq got=%0d wrong bytes exp=0", bad); end
    checks++; if (byte_cnt !== 13'(exp_data.size())) begin errors++; $display("[TB] FAIL max_byte_cnt got=%0d exp=%0d", byte_cnt, exp_data.size()); end
    checks++; if (bus.rd_addr !== 10'(eff_last(10'd1023))) begin errors++; $display("[TB] FAIL max_rd_addr got=%0d exp=%0d", bus.rd_addr, eff_last(10'd1023)); end
    checks++; if (done_cnt - f_done_base != 1) begin errors++; $display("[TB] FAIL max_done_pulses got=%0d exp=1", done_cnt - f_done_base); end
  endtask

  initial begin
    for (int a = 0; a < 1024; a++) ram[a] = $urandom;
    $display("[TB] starting udp_payload_tx bench");
    test_reset();
    test_ready_patterns();
    test_single_word();
    test_restart_ignored();
    test_reset_mid_frame();
    test_max_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/udp_payload_tx.md
UDP_PAYLOAD_TX -- requirements
Module: udp_payload_tx

Interface
REQ-001 SHALL have parameter START_ADDR, default 10'd0: first payload RAM word address read per frame.
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port start_read  input  1  one-cycle pulse: payload RAM holds a complete frame.
REQ-005 SHALL have port last_addr  input  10  last payload word address, valid while start_read is high.
REQ-006 SHALL have port rd_addr  output  10  payload RAM read address; RAM is synchronous read with 1-cycle latency.
REQ-007 SHALL have port rd_data  input  32  payload RAM read data.
REQ-008 SHALL have port out_data  output  8  payload byte.
REQ-009 SHALL have port out_valid  output  1  out_data valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the byte.
REQ-011 SHALL have port out_last  output  1  qualifies the final byte of the frame while out_valid is high.
REQ-012 SHALL have port busy  output  1  frame in progress.
REQ-013 SHALL have port done  output  1  one-cycle pulse at end of frame.
REQ-014 SHALL have port byte_cnt  output  13  bytes accepted in the current or most recent frame.

Function
REQ-015 SHALL implement states IDLE, ADDR, WAIT, SEND, DONE.
REQ-016 In IDLE, start_read high SHALL latch last_addr into end_addr, set rd_addr=START_ADDR and clear byte_cnt; the next state is ADDR.
REQ-017 If the latched last_addr < START_ADDR, the FSM SHALL go IDLE->DONE, and no byte SHALL be emitted.
REQ-018 ADDR->WAIT->SEND SHALL take one cycle per step; on SEND entry rd_data SHALL be captured into a 32-bit word register.
REQ-019 out_valid SHALL first rise 3 cycles after start_read is sampled (T+3).
REQ-020 Byte order SHALL be word[7:0], [15:8], [23:16], [31:24].
REQ-021 A byte SHALL be transferred only on out_valid && out_ready; out_data and out_last SHALL stay stable while out_valid && !out_ready.
REQ-022 Each transfer SHALL increment byte_cnt by 1.
REQ-023 After the 4th byte of a word is accepted: if rd_addr == end_addr, the next state SHALL be DONE; otherwise rd_addr SHALL increment and the next state SHALL be ADDR. out_valid SHALL be low for 3 cycles between words.
REQ-024 out_last SHALL be high only on byte 3 of the final emitted word.
REQ-025 DONE SHALL assert done for exactly 1 cycle and then return to IDLE; byte_cnt SHALL hold until the next start.
REQ-026 busy SHALL be high in every state except IDLE.
REQ-027 start_read SHALL be ignored when the state is not IDLE, including in the DONE cycle.
REQ-028 last_addr=1023 SHALL be supported; rd_addr SHALL never wrap.
REQ-029 out_valid SHALL be registered, with no combinational path from out_ready.

Reset
REQ-030 While rst is low: state=IDLE; rd_addr=START_ADDR; out_data=0; out_valid=0; out_last=0; busy=0; done=0; byte_cnt=0.
REQ-031 Reset asserted mid-frame SHALL drop out_valid immediately (asynchronously) and discard the frame; no done pulse SHALL follow.
REQ-032 The first start_read after release SHALL be honoured.

Configuration
REQ-033 Macro UDP_PAYLOAD_TX_STRIP_FCS_EN defined: the word at end_addr (FCS) SHALL NOT be emitted.
- Effective end is end_addr-1.
- out_last SHALL be on byte 3 of word end_addr-1.
- last_addr <= START_ADDR SHALL give an empty frame: done only, byte_cnt=0.
REQ-034 Macro undefined: every word START_ADDR..last_addr inclusive SHALL be emitted.

Verification
REQ-035 Macro off, out_ready=1, last_addr=2, RAM[0..2]=0x44332211, 0x88776655, 0xCCBBAA99 -> bytes 11..CC in order; first out_valid at T+3; out_last on 0xCC; done once; byte_cnt=12.
REQ-036 Same frame, out_ready toggling 1010... -> identical byte sequence; out_data stable while stalled; byte_cnt=12.
REQ-037 last_addr=0, START_ADDR=0 -> 4 bytes with out_last on the 4th; macro on -> zero bytes, done pulse, byte_cnt=0.
REQ-038 start_read re-pulsed mid-frame with last_addr=5 -> ignored; the original frame completes unchanged.
REQ-039 rst low during byte 2 of word 1 -> out_valid=0 at once; no done; the next start_read with last_addr=0 emits 4 bytes correctly.
REQ-040 last_addr=1023, out_ready=1 -> 4096 bytes; rd_addr ends at 1023 with no wrap; byte_cnt=4096.
